// File: rtl/cajero_controlador_if.sv
// Bundle of card, PIN, keypad and account signals between the ATM controller
// and its environment.
//   master : the environment side (drives card, PIN results, keypad; observes
//            balance and transaction pulses)
//   slave  : the controller side
interface cajero_controlador_if;
  logic        tarjeta_recibida;
  logic        fin;
  logic        bloqueo;
  logic        tipo_stb;
  logic        tipo_trans;
  logic        digito_stb;
  logic [3:0]  digito;
  logic        habilitar_pin;
  logic [63:0] balance;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic        fin_trans;
  logic [2:0]  estado;

  modport master (
    output tarjeta_recibida, fin, bloqueo, tipo_stb, tipo_trans, digito_stb, digito,
    input  habilitar_pin, balance, balance_actualizado, entregar_dinero,
           fondos_insuficientes, fin_trans, estado
  );

  modport slave (
    input  tarjeta_recibida, fin, bloqueo, tipo_stb, tipo_trans, digito_stb, digito,
    output habilitar_pin, balance, balance_actualizado, entregar_dinero,
           fondos_insuficientes, fin_trans, estado
  );
endinterface

// File: rtl/cajero_controlador.sv
// ATM transaction controller: card insertion, PIN hand-off, deposit/withdrawal
// selection, keypad amount entry and balance update.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : cajero_controlador_if.slave
//           inputs  tarjeta_recibida, fin, bloqueo, tipo_stb/tipo_trans,
//                   digito_stb/digito
//           outputs habilitar_pin, balance, balance_actualizado,
//                   entregar_dinero, fondos_insuficientes, fin_trans, estado
// All outputs come straight from flops.
module cajero_controlador #(
  parameter logic [63:0] BALANCE_INICIAL = 64'd1000,
  parameter int unsigned MAX_DIGITOS     = 8
) (
  input logic              clk,
  input logic              reset,
  cajero_controlador_if.slave bus
);

  localparam int unsigned BAL_W   = 64;
  localparam int unsigned MONTO_W = 32;
  localparam int unsigned CNT_W   = $clog2(MAX_DIGITOS + 1);
  localparam logic [3:0]  TECLA_ENTER = 4'hE;

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    ESPERA_PIN       = 3'd1,
    ESPERA_TIPO      = 3'd2,
    RECIBIENDO_MONTO = 3'd3,
    DEPOSITO         = 3'd4,
    RETIRO           = 3'd5,
    FIN_TRANS        = 3'd6,
    BLOQUEADO        = 3'd7
  } estado_t;

  estado_t              state;
  logic [MONTO_W-1:0]   monto;
  logic [CNT_W-1:0]     cnt;
  logic                 tipo;
  logic [BAL_W-1:0]     balance_q;
  logic                 actualizado_q;
  logic                 entregar_q;
  logic                 fondos_q;
  logic                 habilitar_q;
  logic                 fin_trans_q;
  logic [2:0]           estado_q;

  logic [BAL_W:0]       suma;
  logic                 es_digito;
  logic                 hay_espacio;
  logic                 es_enter;

  // Carry bit of the widened sum flags deposit overflow.
  assign suma        = (BAL_W+1)'(balance_q) + (BAL_W+1)'(monto);
  assign es_digito   = bus.digito_stb && (bus.digito <= 4'd9);
  assign hay_espacio = cnt < CNT_W'(MAX_DIGITOS);
  assign es_enter    = bus.digito_stb && (bus.digito == TECLA_ENTER) && (cnt != '0);

  // State change together with the state-decoded level outputs, so those
  // outputs stay registered and aligned with the state register.
  task automatic ir_a(input estado_t s);
    state       <= s;
    estado_q    <= s;
    habilitar_q <= (s == ESPERA_PIN);
    fin_trans_q <= (s == FIN_TRANS);
  endtask

  // Transaction FSM with its datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_a(IDLE);
      balance_q     <= BALANCE_INICIAL;
      monto         <= '0;
      cnt           <= '0;
      tipo          <= 1'b0;
      actualizado_q <= 1'b0;
      entregar_q    <= 1'b0;
      fondos_q      <= 1'b0;
    end else begin
      actualizado_q <= 1'b0;
      entregar_q    <= 1'b0;
      fondos_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tarjeta_recibida) ir_a(ESPERA_PIN);
        end
        ESPERA_PIN: begin
          if (!bus.tarjeta_recibida) ir_a(IDLE);
          else if (bus.bloqueo)      ir_a(BLOQUEADO);
          else if (bus.fin)          ir_a(ESPERA_TIPO);
        end
        ESPERA_TIPO: begin
          if (!bus.tarjeta_recibida) ir_a(IDLE);
          else if (bus.tipo_stb) begin
            tipo  <= bus.tipo_trans;
            monto <= '0;
            cnt   <= '0;
            ir_a(RECIBIENDO_MONTO);
          end
        end
        RECIBIENDO_MONTO: begin
          if (!bus.tarjeta_recibida) ir_a(IDLE);
          else if (es_enter)         ir_a(tipo ? RETIRO : DEPOSITO);
          else if (es_digito && hay_espacio) begin
            monto <= monto * MONTO_W'(10) + MONTO_W'(bus.digito);
            cnt   <= cnt + CNT_W'(1);
          end
        end
        DEPOSITO: begin
          if (!bus.tarjeta_recibida) ir_a(IDLE);
          else begin
            balance_q     <= suma[BAL_W] ? '1 : suma[BAL_W-1:0];
            actualizado_q <= 1'b1;
            ir_a(FIN_TRANS);
          end
        end
        RETIRO: begin
          if (!bus.tarjeta_recibida) ir_a(IDLE);
          else begin
            if (BAL_W'(monto) <= balance_q) begin
              balance_q     <= balance_q - BAL_W'(monto);
              actualizado_q <= 1'b1;
              entregar_q    <= 1'b1;
            end else begin
              fondos_q      <= 1'b1;
            end
            ir_a(FIN_TRANS);
          end
        end
        FIN_TRANS: begin
          if (!bus.tarjeta_recibida) ir_a(IDLE);
        end
        BLOQUEADO: begin
          // Absorbing: only reset leaves this state.
        end
        default: ir_a(IDLE);
      endcase
    end
  end

  assign bus.habilitar_pin        = habilitar_q;
  assign bus.balance              = balance_q;
  assign bus.balance_actualizado  = actualizado_q;
  assign bus.entregar_dinero      = entregar_q;
  assign bus.fondos_insuficientes = fondos_q;
  assign bus.fin_trans            = fin_trans_q;
  assign bus.estado               = estado_q;

endmodule

// File: tb/tb_cajero_controlador.sv
// Bench for cajero_controlador: directed scenarios plus random transactions,
// scored against a transaction-level account model.
module tb_cajero_controlador;

  logic clk;
  logic reset;
  cajero_controlador_if bus();

  cajero_controlador dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned bal;
    bit              act;
    bit              ent;
    bit              fon;
  } ev_t;

  ev_t             exp_q[$];
  longint unsigned bal_m;
  int              checks   = 0;
  int              failures = 0;

  localparam longint unsigned MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tarjeta_recibida = 1'b0;
    bus.fin              = 1'b0;
    bus.bloqueo          = 1'b0;
    bus.tipo_stb         = 1'b0;
    bus.tipo_trans       = 1'b0;
    bus.digito_stb       = 1'b0;
    bus.digito           = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    chk("reset_estado", bus.estado, 0);
    chk("reset_balance", bus.balance, 1000);
    chk("reset_habilitar_pin", bus.habilitar_pin, 0);
    chk("reset_fin_trans", bus.fin_trans, 0);
    reset = 1'b1;
    bal_m = 1000;
  endtask

  task automatic press(input logic [3:0] code);
    bus.digito_stb = 1'b1;
    bus.digito     = code;
    step();
    bus.digito_stb = 1'b0;
    bus.digito     = 4'($urandom_range(15));
  endtask

  // One full card session; the model computes the outcome from the keyed digits.
  task automatic trans(input bit tipo, input int digs[$], input bit abort_e, input bit enter_first);
    longint unsigned monto_m = 0;
    int              n = 0;
    logic [3:0]      junk [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
    ev_t             e;

    bus.tarjeta_recibida = 1'b1;
    step();
    chk("espera_pin_estado", bus.estado, 1);
    chk("espera_pin_habilitar", bus.habilitar_pin, 1);
    bus.fin = 1'b1;
    step();
    bus.fin = 1'b0;
    chk("espera_tipo_estado", bus.estado, 2);
    chk("espera_tipo_habilitar", bus.habilitar_pin, 0);
    bus.tipo_stb   = 1'b1;
    bus.tipo_trans = tipo;
    step();
    bus.tipo_stb   = 1'b0;
    bus.tipo_trans = 1'($urandom_range(1));
    chk("monto_estado", bus.estado, 3);

    if (enter_first) begin
      press(4'hE);
      chk("empty_enter_ignored", bus.estado, 3);
    end
    foreach (digs[i]) begin
      if ($urandom_range(3) == 0) press(junk[$urandom_range(4)]);
      if ($urandom_range(3) == 0) step();
      press(4'(digs[i]));
      if (n < 8) begin
        monto_m = monto_m * 10 + longint'(digs[i]);
        n++;
      end
    end

    bus.digito_stb = 1'b1;
    bus.digito     = 4'hE;
    if (abort_e) bus.tarjeta_recibida = 1'b0;
    step();
    bus.digito_stb = 1'b0;

    if (abort_e) begin
      chk("abort_estado", bus.estado, 0);
      step();
      chk("abort_balance", bus.balance, bal_m);
      chk("abort_estado_hold", bus.estado, 0);
      return;
    end

    chk("op_estado", bus.estado, tipo ? 5 : 4);
    if (!tipo) begin
      bal_m = (bal_m > MAX64 - monto_m) ? MAX64 : bal_m + monto_m;
      e = '{bal_m, 1'b1, 1'b0, 1'b0};
    end else if (monto_m <= bal_m) begin
      bal_m = bal_m - monto_m;
      e = '{bal_m, 1'b1, 1'b1, 1'b0};
    end else begin
      e = '{bal_m, 1'b0, 1'b0, 1'b1};
    end
    exp_q.push_back(e);

    step();
    chk("fin_trans_level", bus.fin_trans, 1);
    chk("fin_trans_estado", bus.estado, 6);
    step();
    chk("pulse_seen", exp_q.size(), 0);
    chk("fin_trans_hold", bus.fin_trans, 1);
    bus.tarjeta_recibida = 1'b0;
    step();
    chk("card_out_estado", bus.estado, 0);
    chk("card_out_fin_trans", bus.fin_trans, 0);
    chk("card_out_balance", bus.balance, bal_m);
  endtask

  // Monitor: every pulse cycle must match the oldest expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.balance_actualizado || bus.entregar_dinero || bus.fondos_insuficientes) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse",
              {61'd0, bus.balance_actualizado, bus.entregar_dinero, bus.fondos_insuficientes}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_balance", bus.balance, e.bal);
          chk("pulse_actualizado", bus.balance_actualizado, e.act);
          chk("pulse_entregar", bus.entregar_dinero, e.ent);
          chk("pulse_fondos", bus.fondos_insuficientes, e.fon);
        end
      end
    end
  end

  initial begin
    int digs[$];
    idle_inputs();
    reset = 1'b0;
    bal_m = 1000;

    // Deposit 250.
    do_reset();
    digs = '{2, 5, 0};
    trans(1'b0, digs, 1'b0, 1'b0);
    chk("deposit_balance", bus.balance, 1250);

    // Approved withdrawal of 400.
    do_reset();
    digs = '{4, 0, 0};
    trans(1'b1, digs, 1'b0, 1'b0);
    chk("withdraw_balance", bus.balance, 600);

    // Rejected withdrawal of 1500.
    do_reset();
    digs = '{1, 5, 0, 0};
    trans(1'b1, digs, 1'b0, 1'b0);
    chk("reject_balance", bus.balance, 1000);

    // Empty enter, then nine 9s: only eight are taken.
    do_reset();
    digs = '{9, 9, 9, 9, 9, 9, 9, 9, 9};
    trans(1'b0, digs, 1'b0, 1'b1);
    chk("digit_limit_balance", bus.balance, 100000999);

    // Card pulled together with enter.
    do_reset();
    digs = '{3, 3};
    trans(1'b0, digs, 1'b1, 1'b0);

    // Blocking beats fin; the block is absorbing until reset.
    do_reset();
    bus.tarjeta_recibida = 1'b1;
    step();
    bus.bloqueo = 1'b1;
    bus.fin     = 1'b1;
    step();
    chk("blocked_estado", bus.estado, 7);
    for (int i = 0; i < 12; i++) begin
      bus.tarjeta_recibida = 1'($urandom_range(1));
      bus.fin              = 1'($urandom_range(1));
      bus.bloqueo          = 1'($urandom_range(1));
      bus.tipo_stb         = 1'($urandom_range(1));
      bus.tipo_trans       = 1'($urandom_range(1));
      bus.digito_stb       = 1'($urandom_range(1));
      bus.digito           = 4'($urandom_range(15));
      step();
      chk("blocked_hold_estado", bus.estado, 7);
      chk("blocked_habilitar", bus.habilitar_pin, 0);
    end
    do_reset();

    // Random sessions on a running balance.
    for (int t = 0; t < 30; t++) begin
      bit tp;
      int nd;
      tp = 1'($urandom_range(1));
      nd = tp ? $urandom_range(5, 1) : $urandom_range(10, 1);
      digs.delete();
      for (int k = 0; k < nd; k++) digs.push_back($urandom_range(9));
      trans(tp, digs, ($urandom_range(7) == 0), ($urandom_range(5) == 0));
      if ($urandom_range(2) == 0) step();
    end

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
